// File: rtl/fib_param_pkg.sv
// Shared definitions for the Fibonacci/Lucas sequencer: FSM encoding,
// sequence-select constants and seed terms.
package fib_param_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOOP = 1'b1
    } state_t;

    localparam logic MODE_FIB   = 1'b0;
    localparam logic MODE_LUCAS = 1'b1;

    localparam int FIB_SEED0   = 0;
    localparam int FIB_SEED1   = 1;
    localparam int LUCAS_SEED0 = 2;
    localparam int LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_param_if.sv
// Request/response bundle for fib_param: start/abort/args from the requester,
// ready/done/result/overflow back from the sequencer.
interface fib_param_if #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 32
);
    logic               start;
    logic               abort;
    logic [N_WIDTH-1:0] n;
    logic               mode;
    logic               ready;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic               overflow;

    // start is taken on a rising edge where ready=1; done pulses one cycle
    // and result/overflow stay valid until the next done.
    modport master (
        output start, abort, n, mode,
        input  ready, done, result, overflow
    );

    modport slave (
        input  start, abort, n, mode,
        output ready, done, result, overflow
    );
endinterface

// File: rtl/fib_param_step.sv
// Combinational next-term datapath: sum of the two live terms plus the
// per-term overflow flags shifted along with the terms.
module fib_param_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ovf_a_i,
    input  logic             ovf_b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_a_o,
    output logic             ovf_b_o
);
    logic [WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i};
    assign sum_o    = full_sum[WIDTH-1:0];
    // A new term is out of range if either addend already was or the add carried.
    assign ovf_a_o  = ovf_b_i;
    assign ovf_b_o  = ovf_a_i | ovf_b_i | full_sum[WIDTH];
endmodule

// File: rtl/fib_param.sv
// Iterative Fibonacci/Lucas term generator with abort, optional saturation
// and a one-cycle completion pulse.
module fib_param
    import fib_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_WIDTH  = 32,
    parameter int SATURATE = 0
) (
    input  logic               __func_clock,
    input  logic               __func_reset,
    input  logic               __func_start,
    input  logic               __func_abort,
    input  logic [N_WIDTH-1:0] __args_n,
    input  logic               __args_mode,
    output logic               __func_ready,
    output logic               __func_done,
    output logic [WIDTH-1:0]   __func_result,
    output logic               __func_overflow,
    output state_t             dbg_state_o
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [N_WIDTH-1:0] count_q, count_d;
    logic               ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   sum;
    logic               ovf_a_nx, ovf_b_nx;

    fib_param_step #(.WIDTH(WIDTH)) u_step (
        .a_i     (a_q),
        .b_i     (b_q),
        .ovf_a_i (ovf_a_q),
        .ovf_b_i (ovf_b_q),
        .sum_o   (sum),
        .ovf_a_o (ovf_a_nx),
        .ovf_b_o (ovf_b_nx)
    );

    always_ff @(posedge __func_clock or posedge __func_reset) begin
        if (__func_reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            count_q    <= '0;
            ovf_a_q    <= 1'b0;
            ovf_b_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            count_q    <= count_d;
            ovf_a_q    <= ovf_a_d;
            ovf_b_q    <= ovf_b_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        count_d    = count_q;
        ovf_a_d    = ovf_a_q;
        ovf_b_d    = ovf_b_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (__func_start) begin
                    a_d     = (__args_mode == MODE_LUCAS) ? WIDTH'(LUCAS_SEED0) : WIDTH'(FIB_SEED0);
                    b_d     = (__args_mode == MODE_LUCAS) ? WIDTH'(LUCAS_SEED1) : WIDTH'(FIB_SEED1);
                    count_d = __args_n;
                    ovf_a_d = 1'b0;
                    ovf_b_d = 1'b0;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                // Abort takes priority over the count==0 completion.
                if (__func_abort) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    result_d   = (SATURATE != 0 && ovf_a_q) ? '1 : a_q;
                    overflow_d = ovf_a_q;
                    done_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    a_d     = b_q;
                    b_d     = sum;
                    ovf_a_d = ovf_a_nx;
                    ovf_b_d = ovf_b_nx;
                    count_d = count_q - N_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign __func_ready    = (state_q == S_IDLE);
    assign __func_done     = done_q;
    assign __func_result   = result_q;
    assign __func_overflow = overflow_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_fib_param.sv
// Bench for fib_param: three instances (32-bit, 8-bit wrapping, 8-bit
// saturating) share one stimulus stream and are compared every cycle.
module tb_fib_param;
  import fib_param_pkg::*;

  localparam int NW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_s = 1'b0;
  logic          abort_s = 1'b0;
  logic [NW-1:0] n_s     = '0;
  logic          mode_s  = 1'b0;

  int checks = 0;
  int errors = 0;

  fib_param_if #(.WIDTH(32), .N_WIDTH(NW)) if32 ();
  fib_param_if #(.WIDTH(8),  .N_WIDTH(NW)) if8 ();
  fib_param_if #(.WIDTH(8),  .N_WIDTH(NW)) if8s ();

  assign if32.start = start_s;  assign if32.abort = abort_s;
  assign if32.n     = n_s;      assign if32.mode  = mode_s;
  assign if8.start  = start_s;  assign if8.abort  = abort_s;
  assign if8.n      = n_s;      assign if8.mode   = mode_s;
  assign if8s.start = start_s;  assign if8s.abort = abort_s;
  assign if8s.n     = n_s;      assign if8s.mode  = mode_s;

  state_t st32, st8, st8s;

  fib_param #(.WIDTH(32), .N_WIDTH(NW), .SATURATE(0)) dut32 (
    .__func_clock(clk), .__func_reset(rst),
    .__func_start(if32.start), .__func_abort(if32.abort),
    .__args_n(if32.n), .__args_mode(if32.mode),
    .__func_ready(if32.ready), .__func_done(if32.done),
    .__func_result(if32.result), .__func_overflow(if32.overflow),
    .dbg_state_o(st32)
  );

  fib_param #(.WIDTH(8), .N_WIDTH(NW), .SATURATE(0)) dut8 (
    .__func_clock(clk), .__func_reset(rst),
    .__func_start(if8.start), .__func_abort(if8.abort),
    .__args_n(if8.n), .__args_mode(if8.mode),
    .__func_ready(if8.ready), .__func_done(if8.done),
    .__func_result(if8.result), .__func_overflow(if8.overflow),
    .dbg_state_o(st8)
  );

  fib_param #(.WIDTH(8), .N_WIDTH(NW), .SATURATE(1)) dut8s (
    .__func_clock(clk), .__func_reset(rst),
    .__func_start(if8s.start), .__func_abort(if8s.abort),
    .__args_n(if8s.n), .__args_mode(if8s.mode),
    .__func_ready(if8s.ready), .__func_done(if8s.done),
    .__func_result(if8s.result), .__func_overflow(if8s.overflow),
    .dbg_state_o(st8s)
  );

  // ---------------- reference model ----------------
  // Term n from the recurrence; overflow means the exact term exceeds
  // 2^w-1 (exact value tracked with a cap at 2^w).
  function automatic void model(input int unsigned n, input logic md, input int w,
                                input bit sat, output longint unsigned res, output bit ovf);
    longint unsigned mask, cap, ma, mb, ea, eb, t;
    mask = (64'd1 << w) - 64'd1;
    cap  = mask + 64'd1;
    ma   = md ? 64'd2 : 64'd0;
    mb   = 64'd1;
    ea   = ma;
    eb   = mb;
    for (int unsigned i = 0; i < n; i++) begin
      t  = (ma + mb) & mask;
      ma = mb;
      mb = t;
      t  = ea + eb;
      if (t > cap) t = cap;
      ea = eb;
      eb = t;
    end
    ovf = (ea > mask);
    res = (sat && ovf) ? mask : ma;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [32:0] exp32_q[$];
  logic [8:0]  exp8_q[$];
  logic [8:0]  exp8s_q[$];

  bit          busy     = 1'b0;
  int          rem      = 0;
  bit          e_done   = 1'b0;
  logic [31:0] e_res32  = '0;
  logic [7:0]  e_res8   = '0;
  logic [7:0]  e_res8s  = '0;
  bit          e_ovf32  = 1'b0;
  bit          e_ovf8   = 1'b0;
  bit          e_ovf8s  = 1'b0;

  always @(posedge clk or posedge rst) begin
    longint unsigned r;
    bit o;
    logic [32:0] p32;
    logic [8:0]  p8, p8s;
    if (rst) begin
      busy = 0; rem = 0; e_done = 0;
      e_res32 = '0; e_res8 = '0; e_res8s = '0;
      e_ovf32 = 0; e_ovf8 = 0; e_ovf8s = 0;
      exp32_q.delete(); exp8_q.delete(); exp8s_q.delete();
    end else begin
      e_done = 0;
      if (!busy) begin
        if (start_s) begin
          busy = 1;
          rem  = int'(n_s) + 1;
          model(n_s, mode_s, 32, 0, r, o); exp32_q.push_back({o, r[31:0]});
          model(n_s, mode_s, 8, 0, r, o);  exp8_q.push_back({o, r[7:0]});
          model(n_s, mode_s, 8, 1, r, o);  exp8s_q.push_back({o, r[7:0]});
        end
      end else begin
        rem--;
        if (abort_s) begin
          busy = 0;
          void'(exp32_q.pop_front()); void'(exp8_q.pop_front()); void'(exp8s_q.pop_front());
        end else if (rem == 0) begin
          busy   = 0;
          e_done = 1;
          p32 = exp32_q.pop_front(); p8 = exp8_q.pop_front(); p8s = exp8s_q.pop_front();
          {e_ovf32, e_res32} = p32;
          {e_ovf8, e_res8}   = p8;
          {e_ovf8s, e_res8s} = p8s;
        end
      end
    end
  end

  // Every-cycle comparison, half a period away from the active edge.
  always @(negedge clk) begin
    chk("ready32", if32.ready, !busy);
    chk("done32",  if32.done,  e_done);
    chk("res32",   if32.result, e_res32);
    chk("ovf32",   if32.overflow, e_ovf32);
    chk("idle32",  st32 == S_IDLE, !busy);
    chk("ready8",  if8.ready, !busy);
    chk("done8",   if8.done,  e_done);
    chk("res8",    if8.result, e_res8);
    chk("ovf8",    if8.overflow, e_ovf8);
    chk("ready8s", if8s.ready, !busy);
    chk("done8s",  if8s.done,  e_done);
    chk("res8s",   if8s.result, e_res8s);
    chk("ovf8s",   if8s.overflow, e_ovf8s);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one request and measure cycles from the accepting edge to done.
  task automatic run_req(input int nn, input logic md);
    int cyc;
    bit got;
    start_s = 1'b1; n_s = NW'(nn); mode_s = md;
    tick();
    start_s = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < nn + 20) begin
      tick();
      cyc++;
      if (if32.done) got = 1;
    end
    chk($sformatf("latency_n%0d", nn), got ? cyc : -1, nn + 1);
  endtask

  // ---------------- main sequence ----------------
  int fib_lit[7] = '{0, 1, 1, 2, 3, 5, 8};

  initial begin
    longint unsigned r;
    bit o;
    int dones;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // pin the model to hand-computed values
    model(6, 0, 32, 0, r, o);  chk("model_fib6", {o, r}, {1'b0, 64'd8});
    model(5, 1, 32, 0, r, o);  chk("model_luc5", {o, r}, {1'b0, 64'd11});
    model(13, 0, 8, 0, r, o);  chk("model_fib13_w8", {o, r}, {1'b0, 64'd233});
    model(14, 0, 8, 0, r, o);  chk("model_fib14_w8", {o, r}, {1'b1, 64'd121});
    model(14, 0, 8, 1, r, o);  chk("model_fib14_w8s", {o, r}, {1'b1, 64'd255});

    // Fibonacci n=0..6 with literal results
    for (int i = 0; i < 7; i++) begin
      run_req(i, MODE_FIB);
      chk($sformatf("fib_lit_%0d", i), if32.result, fib_lit[i]);
      chk($sformatf("fib_ovf_%0d", i), if32.overflow, 1'b0);
    end

    // Lucas
    run_req(0, MODE_LUCAS);  chk("luc0", if32.result, 32'd2);
    run_req(5, MODE_LUCAS);  chk("luc5", if32.result, 32'd11);

    // 8-bit overflow boundary
    run_req(13, MODE_FIB);
    chk("w8_13_res", if8.result, 8'd233);  chk("w8_13_ovf", if8.overflow, 1'b0);
    chk("w8s_13_res", if8s.result, 8'd233);
    run_req(14, MODE_FIB);
    chk("w8_14_res", if8.result, 8'd121);  chk("w8_14_ovf", if8.overflow, 1'b1);
    chk("w8s_14_res", if8s.result, 8'd255); chk("w8s_14_ovf", if8s.overflow, 1'b1);

    // abort mid-run keeps the previous result
    run_req(5, MODE_FIB);
    start_s = 1'b1; n_s = 8'd20; mode_s = MODE_FIB;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("abort_ready", if32.ready, 1'b1);
    chk("abort_nodone", if32.done, 1'b0);
    chk("abort_keep", if32.result, 32'd5);
    run_req(6, MODE_FIB);
    chk("after_abort", if32.result, 32'd8);

    // reset mid-run, with start held during reset
    start_s = 1'b1; n_s = 8'd10;
    tick();
    start_s = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_res", if32.result, 32'd0);
    chk("rst_ovf", if8.overflow, 1'b0);
    chk("rst_ready", if32.ready, 1'b1);
    chk("rst_done", if32.done, 1'b0);
    start_s = 1'b1;
    tick();
    tick();
    start_s = 1'b0;
    rst = 1'b0;
    run_req(3, MODE_FIB);
    chk("after_rst", if32.result, 32'd2);

    // start during LOOP ignored, start in done cycle accepted
    dones = 0;
    start_s = 1'b1; n_s = 8'd3; mode_s = MODE_FIB;
    tick();
    n_s = 8'd9;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if32.done) begin
        dones++;
        if (dones == 1) begin
          start_s = 1'b1; n_s = 8'd4; mode_s = MODE_LUCAS;
        end
      end
      tick();
      start_s = 1'b0;
    end
    chk("b2b_dones", dones, 2);
    chk("b2b_res", if32.result, 32'd7);

    // largest index runs to completion
    run_req(255, MODE_FIB);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start_s = ($urandom_range(0, 3) == 0);
      abort_s = ($urandom_range(0, 24) == 0);
      mode_s  = $urandom_range(0, 1);
      n_s     = ($urandom_range(0, 19) == 0) ? NW'($urandom_range(0, 255))
                                             : NW'($urandom_range(0, 30));
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    start_s = 1'b0; abort_s = 1'b0; rst = 1'b0;
    repeat (300) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
